// File: rtl/pma_tx_symb_buffer.sv
// Elastic PAM5 symbol buffer between PCS TX encoder and PMA TX, with symbol timer and underflow idle fill.
// Optional feature macro: PAM5_RANGE_CHECK_EN (illegal PAM5 codes stored as 0 and flagged on io_sym_err).
module pma_tx_symb_buffer #(
  parameter int DEPTH     = 4,
  parameter int SYMB_DIV  = 1,
  parameter int PRIME_LVL = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_enable,
  input  logic                         io_clr_status,
  input  logic                         io_tx_symb_vector_valid,
  output logic                         io_tx_symb_vector_ready,
  input  logic [2:0]                   io_tx_symb_vector_bits_0,
  input  logic [2:0]                   io_tx_symb_vector_bits_1,
  input  logic [2:0]                   io_tx_symb_vector_bits_2,
  input  logic [2:0]                   io_tx_symb_vector_bits_3,
  output logic                         io_symb_timer_done,
  output logic                         io_pma_tx_strobe,
  output logic [2:0]                   io_pma_tx_a,
  output logic [2:0]                   io_pma_tx_b,
  output logic [2:0]                   io_pma_tx_c,
  output logic [2:0]                   io_pma_tx_d,
  output logic [$clog2(DEPTH+1)-1:0]   io_level,
  output logic                         io_underflow,
  output logic                         io_sym_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = (SYMB_DIV > 1) ? $clog2(SYMB_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [LVL_W-1:0]   r_level;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [11:0]        r_mem [DEPTH];
  logic               r_underflow;
  logic               r_sym_err;
  logic               r_strobe;
  logic [11:0]        r_out;

  logic               w_flush;
  logic               w_tick;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_uf_evt;
  logic               w_err_evt;
  logic [11:0]        w_wr_data;

`ifdef PAM5_RANGE_CHECK_EN
  function automatic logic f_pam5_bad(input logic [2:0] s);
    case (s)
      3'b011, 3'b100, 3'b101: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_pam5_clip(input logic [2:0] s);
    return f_pam5_bad(s) ? 3'b000 : s;
  endfunction

  assign w_wr_data = {f_pam5_clip(io_tx_symb_vector_bits_3), f_pam5_clip(io_tx_symb_vector_bits_2),
                      f_pam5_clip(io_tx_symb_vector_bits_1), f_pam5_clip(io_tx_symb_vector_bits_0)};
  assign w_err_evt = w_push && (f_pam5_bad(io_tx_symb_vector_bits_0) || f_pam5_bad(io_tx_symb_vector_bits_1) ||
                                f_pam5_bad(io_tx_symb_vector_bits_2) || f_pam5_bad(io_tx_symb_vector_bits_3));
`else
  assign w_wr_data = {io_tx_symb_vector_bits_3, io_tx_symb_vector_bits_2,
                      io_tx_symb_vector_bits_1, io_tx_symb_vector_bits_0};
  assign w_err_evt = 1'b0;
`endif

  // Timer is parked at 0 in IDLE so the first tick lands SYMB_DIV cycles into FILL.
  assign w_flush  = !io_enable || (r_state == ST_IDLE);
  assign w_tick   = io_enable && (r_state != ST_IDLE) && (r_cnt == CNT_W'(SYMB_DIV - 1));
  assign w_ready  = (r_state != ST_IDLE) && (r_level < LVL_W'(DEPTH));
  assign w_push   = io_tx_symb_vector_valid && w_ready;
  assign w_pop    = w_tick && (((r_state == ST_FILL) && (r_level >= LVL_W'(PRIME_LVL))) ||
                               ((r_state == ST_RUN) && (r_level != {LVL_W{1'b0}})));
  assign w_uf_evt = w_tick && (r_state == ST_RUN) && (r_level == {LVL_W{1'b0}});

  // Next-state logic for the fill/run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    if (!io_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_FILL;
        ST_FILL: w_state_nxt = w_pop ? ST_RUN : ST_FILL;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and symbol-period timer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_flush || (r_cnt == CNT_W'(SYMB_DIV - 1))) r_cnt <= {CNT_W{1'b0}};
      else                                            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // FIFO storage; pops always read an entry written in an earlier cycle.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else if (w_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // PMA output register: one strobe per tick in RUN, idle-level zeros on underflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_strobe <= 1'b0;
      r_out    <= 12'h000;
    end else if (w_flush) begin
      r_strobe <= 1'b0;
      r_out    <= 12'h000;
    end else if (w_pop) begin
      r_strobe <= 1'b1;
      r_out    <= r_mem[r_rd_ptr];
    end else if (w_uf_evt) begin
      r_strobe <= 1'b1;
      r_out    <= 12'h000;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  // Sticky status; a set event beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
      r_sym_err   <= 1'b0;
    end else begin
      if (w_uf_evt)           r_underflow <= 1'b1;
      else if (io_clr_status) r_underflow <= 1'b0;
      if (w_err_evt)          r_sym_err   <= 1'b1;
      else if (io_clr_status) r_sym_err   <= 1'b0;
    end
  end

  assign io_tx_symb_vector_ready = w_ready;
  assign io_symb_timer_done      = w_tick;
  assign io_pma_tx_strobe        = r_strobe;
  assign io_pma_tx_a             = r_out[2:0];
  assign io_pma_tx_b             = r_out[5:3];
  assign io_pma_tx_c             = r_out[8:6];
  assign io_pma_tx_d             = r_out[11:9];
  assign io_level                = r_level;
  assign io_underflow            = r_underflow;
  assign io_sym_err              = r_sym_err;

endmodule
